// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default constants for the CPU run controller.
// Optional feature macro: RUN_CTRL_TIMEOUT_EN (adds the TIMEOUT state).
package run_ctrl_pkg;

  localparam int TIMEOUT_DEF = 4096;
  localparam int RST_CYC_DEF = 2;
  localparam int MEM_AW      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RST     = 3'd2,
    ST_RUN     = 3'd3,
`ifdef RUN_CTRL_TIMEOUT_EN
    ST_TIMEOUT = 3'd5,
`endif
    ST_DONE    = 3'd4
  } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Preload stream, data-memory write port and core handshake bundle.
// master = run controller side, slave = harness/core side.
interface cpu_run_ctrl_if;
  import run_ctrl_pkg::*;

  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              mem_wr_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wr_data;
  logic              core_reset;
  logic              core_req;
  logic              core_done;

  modport master (
    input  ld_valid, ld_data, ld_last, core_done,
    output ld_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset, core_req
  );

  modport slave (
    output ld_valid, ld_data, ld_last, core_done,
    input  ld_ready, mem_wr_en, mem_addr, mem_wr_data, core_reset, core_req
  );
endinterface

// File: rtl/cpu_run_ctrl_timer.sv
// RUN-cycle counter with clear, enable (freeze when low) and timeout match.
// With RUN_CTRL_TIMEOUT_EN undefined the counter saturates and has no match output.
module run_timer #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o
`ifdef RUN_CTRL_TIMEOUT_EN
  ,
  output logic          tmo_o
`endif
);

  logic [CW-1:0] count_q, count_d;

  // next count: clear has priority, otherwise count while enabled
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
`ifdef RUN_CTRL_TIMEOUT_EN
      count_d = count_q + CW'(1);
`else
      if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
`endif
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
`ifdef RUN_CTRL_TIMEOUT_EN
  assign tmo_o = (count_q == CW'(TIMEOUT - 1));
`endif

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: preloads data memory from a byte stream, holds the core in
// reset for RST_CYC cycles, pulses req, then counts RUN cycles until done.
// Optional feature macro: RUN_CTRL_TIMEOUT_EN (TIMEOUT abort state).
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  cpu_run_ctrl_if.master      bus,
  output logic                busy,
  output logic                finished,
  output logic                timed_out,
  output logic [CW-1:0]       cycle_count
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t        state_q, state_d;
  logic [RW-1:0]     rst_cnt_q;
  logic [MEM_AW-1:0] addr_cnt_q;
  logic              wr_en_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [7:0]        wr_data_q;
  logic              core_reset_q, core_req_q;
  logic              busy_q, finished_q;
  logic              accept, start_ok, tmo_hit;

  assign bus.ld_ready = (state_q == ST_LOAD);
  assign accept       = bus.ld_valid && (state_q == ST_LOAD);
  assign start_ok     = start && !(state_q == ST_LOAD || state_q == ST_RST || state_q == ST_RUN);

  run_timer #(.CW(CW), .TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (start_ok),
    .en_i    ((state_q == ST_RUN) && !bus.core_done),
    .count_o (cycle_count)
`ifdef RUN_CTRL_TIMEOUT_EN
    ,
    .tmo_o   (tmo_hit)
`endif
  );
`ifndef RUN_CTRL_TIMEOUT_EN
  assign tmo_hit = 1'b0;
`endif

  // next-state decode; done beats timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_LOAD;
`ifdef RUN_CTRL_TIMEOUT_EN
      ST_TIMEOUT:       if (start_ok) state_d = ST_LOAD;
`endif
      ST_LOAD: if (accept && (bus.ld_last || addr_cnt_q == {MEM_AW{1'b1}})) state_d = ST_RST;
      ST_RST:  if (rst_cnt_q == RW'(RST_CYC - 1)) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.core_done) state_d = ST_DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (tmo_hit) state_d = ST_TIMEOUT;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, preload datapath and registered outputs decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      addr_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      wr_data_q    <= '0;
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= (state_q == ST_RST && state_d == ST_RST) ? rst_cnt_q + RW'(1) : '0;
      if (start_ok)    addr_cnt_q <= '0;
      else if (accept) addr_cnt_q <= addr_cnt_q + MEM_AW'(1);
      wr_en_q <= accept;
      if (accept) begin
        mem_addr_q <= addr_cnt_q;
        wr_data_q  <= bus.ld_data;
      end
      core_reset_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_RST);
      core_req_q   <= (state_d == ST_RUN) && (state_q != ST_RUN);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_RST) || (state_d == ST_RUN);
      finished_q   <= (state_d == ST_DONE);
    end
  end

`ifdef RUN_CTRL_TIMEOUT_EN
  logic timed_out_q;
  // sticky timeout flag, cleared by reset or restart
  always_ff @(posedge clk) begin
    if (reset) timed_out_q <= 1'b0;
    else       timed_out_q <= (state_d == ST_TIMEOUT);
  end
  assign timed_out = timed_out_q;
`else
  assign timed_out = 1'b0;
`endif

  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.core_reset  = core_reset_q;
  assign bus.core_req    = core_req_q;
  assign busy            = busy_q;
  assign finished        = finished_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (CW=8, TIMEOUT=16, RST_CYC=2).
module tb_cpu_run_ctrl;
  logic       clk;
  logic       reset;
  logic       start;
  logic       busy, finished, timed_out;
  logic [7:0] cycle_count;
  int         n_cmp = 0;
  int         n_err = 0;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.CW(8), .TIMEOUT(16), .RST_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus.master),
    .busy        (busy),
    .finished    (finished),
    .timed_out   (timed_out),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, bus.core_reset, 1);
    chk({tag, "_core_req"}, bus.core_req, 0);
    chk({tag, "_ld_ready"}, bus.ld_ready, 0);
    chk({tag, "_wr_en"}, bus.mem_wr_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  initial begin
    logic [7:0] bytes4 [4];
    bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
    reset = 1'b1; start = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0; bus.core_done = 1'b0;
    tick(); tick();
    chk_reset_vals("por");

    // ---- load 4 bytes and run, done 50 cycles into RUN
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ld_ready", bus.ld_ready, 1);
    chk("t1_core_reset_load", bus.core_reset, 1);
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = bytes4[i]; bus.ld_last = (i == 3);
      tick();
      chk("t1_wr_en", bus.mem_wr_en, 1);
      chk("t1_addr", bus.mem_addr, i);
      chk("t1_wdata", bus.mem_wr_data, bytes4[i]);
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("t1_ld_ready_rst", bus.ld_ready, 0);
    chk("t1_core_reset_rst1", bus.core_reset, 1);
    tick();
    chk("t1_core_reset_rst2", bus.core_reset, 1);
    chk("t1_wr_en_off", bus.mem_wr_en, 0);
    chk("t1_req_rst", bus.core_req, 0);
    tick();
    chk("t1_core_reset_run", bus.core_reset, 0);
    chk("t1_req_pulse", bus.core_req, 1);
    chk("t1_count0", cycle_count, 0);
    tick();
    chk("t1_req_single", bus.core_req, 0);
    chk("t1_count1", cycle_count, 1);
    repeat (49) tick();
    chk("t1_count50", cycle_count, 50);
    chk("t1_not_finished", finished, 0);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("t1_finished", finished, 1);
    chk("t1_count_final", cycle_count, 50);
    chk("t1_busy_done", busy, 0);
    chk("t1_core_reset_done", bus.core_reset, 0);
    chk("t1_timed_out", timed_out, 0);
    tick();
    chk("t1_count_hold", cycle_count, 50);
    chk("t1_finished_sticky", finished, 1);

    // ---- restart from DONE, 256 bytes without last, start while busy ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_finished_clr", finished, 0);
    chk("t2_count_clr", cycle_count, 0);
    chk("t2_busy", busy, 1);
    for (int i = 0; i < 256; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 8'(i) ^ 8'h5A; bus.ld_last = 1'b0;
      start = (i == 100);
      tick();
      if (bus.mem_addr !== 8'(i) || bus.mem_wr_data !== (8'(i) ^ 8'h5A) || bus.mem_wr_en !== 1'b1)
        chk("t2_write", {bus.mem_wr_en, bus.mem_wr_data, bus.mem_addr}, {1'b1, 8'(i) ^ 8'h5A, 8'(i)});
    end
    start = 1'b0;
    chk("t2_last_addr", bus.mem_addr, 255);
    chk("t2_last_data", bus.mem_wr_data, 8'hFF ^ 8'h5A);
    chk("t2_ld_ready_off", bus.ld_ready, 0);
    chk("t2_core_reset_rst", bus.core_reset, 1);
    bus.ld_data = 8'hEE;
    tick();
    bus.ld_valid = 1'b0;
    chk("t2_extra_rejected", bus.mem_wr_en, 0);
    chk("t2_ld_ready_still_off", bus.ld_ready, 0);
    tick();
    chk("t2_req", bus.core_req, 1);

    // ---- done coincides with count == TIMEOUT-1
    repeat (15) tick();
    chk("t3_count15", cycle_count, 15);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("t3_finished", finished, 1);
    chk("t3_timed_out", timed_out, 0);
    chk("t3_count", cycle_count, 15);

    // ---- single-byte load, then timeout or saturation
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 8'hA5; bus.ld_last = 1'b1;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("t4_wr_en", bus.mem_wr_en, 1);
    chk("t4_addr", bus.mem_addr, 0);
    chk("t4_wdata", bus.mem_wr_data, 8'hA5);
    chk("t4_ld_ready", bus.ld_ready, 0);
    tick();
    chk("t4_single_write", bus.mem_wr_en, 0);
    tick();
    chk("t4_req", bus.core_req, 1);
`ifdef RUN_CTRL_TIMEOUT_EN
    repeat (16) tick();
    chk("t4_timed_out", timed_out, 1);
    chk("t4_count16", cycle_count, 16);
    chk("t4_finished", finished, 0);
    chk("t4_busy", busy, 0);
    chk("t4_core_reset", bus.core_reset, 0);
    tick();
    chk("t4_count_hold", cycle_count, 16);
    chk("t4_sticky", timed_out, 1);
`else
    repeat (300) tick();
    chk("t4_sat_count", cycle_count, 255);
    chk("t4_sat_busy", busy, 1);
    chk("t4_sat_timed_out", timed_out, 0);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("t4_sat_finished", finished, 1);
    chk("t4_sat_count_hold", cycle_count, 255);
`endif

    // ---- restart, reload from 0, start ignored in RUN, reset mid-RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_flags_clr", {finished, timed_out}, 0);
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = 8'hC0 + 8'(i); bus.ld_last = (i == 1);
      tick();
      chk("t5_addr", bus.mem_addr, i);
      chk("t5_wdata", bus.mem_wr_data, 8'hC0 + 8'(i));
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    tick(); tick();
    chk("t5_req", bus.core_req, 1);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_start_ignored_busy", busy, 1);
    chk("t5_start_ignored_ready", bus.ld_ready, 0);
    chk("t5_start_ignored_count", cycle_count, 6);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_midrun");

    // ---- reset drops an in-flight write
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_load", bus.ld_ready, 1);
    bus.ld_valid = 1'b1; bus.ld_data = 8'h77;
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.ld_valid = 1'b0;
    chk("t6_wr_dropped", bus.mem_wr_en, 0);
    chk("t6_ready", bus.ld_ready, 0);
    chk("t6_core_reset", bus.core_reset, 1);
    tick();
    chk("t6_no_late_write", bus.mem_wr_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that sits directly upstream of the processor top level. It preloads the data memory from a byte stream, then holds the core in reset and releases it. It pulses `req`, watches `done`, and counts execution cycles. It reports completion or timeout to the test harness or host.

## Interface
Parameters:
- `CW`, 16, cycle-counter width
- `TIMEOUT`, 4096, maximum RUN cycles before abort; must be at most 2^CW
- `RST_CYC`, 2, number of cycles `core_reset` is held high before the run; must be at least 1

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin load-and-run; sampled only in IDLE, DONE and TIMEOUT
- `ld_valid`  in  1  preload byte valid
- `ld_data`  in  8  preload byte
- `ld_last`  in  1  final preload byte, qualified by `ld_valid`
- `ld_ready`  out  1  preload byte accepted when `ld_valid && ld_ready`
- `mem_wr_en`  out  1  data-memory write strobe (external mux to `dat_mem`)
- `mem_addr`  out  8  data-memory write address
- `mem_wr_data`  out  8  data-memory write data
- `core_reset`  out  1  drives the core's `reset`
- `core_req`  out  1  drives the core's `req`
- `core_done`  in  1  from the core's `done`
- `busy`  out  1  high in LOAD, RST and RUN
- `finished`  out  1  sticky; high in DONE
- `timed_out`  out  1  sticky; high in TIMEOUT
- `cycle_count`  out  CW  RUN cycles elapsed

## Operation
- **States:** IDLE, LOAD, RST, RUN, DONE, TIMEOUT.
- **IDLE:**
  - `core_reset` is 1.
  - On `start`, go to LOAD and clear `cycle_count`, the address counter, `finished` and `timed_out`.
- **LOAD:**
  - `ld_ready` is 1.
  - Each accepted byte is registered: the next cycle has `mem_wr_en`=1, `mem_addr`=current address, `mem_wr_data`=byte. The address then increments and wraps from 255 to 0.
  - An accepted `ld_last`, or acceptance at address 255, moves the FSM to RST.
  - Bytes beyond 256 are not accepted.
- **RST:**
  - `core_reset` is 1 for exactly `RST_CYC` cycles, then the FSM goes to RUN.
  - The final registered write lands in the first RST cycle.
- **RUN:**
  - `core_reset` is 0.
  - `core_req` is 1 for the first RUN cycle only.
  - `cycle_count` increments on each cycle where `core_done`=0.
  - `core_done`=1 moves the FSM to DONE and freezes the count.
  - With no `core_done` and `cycle_count`==`TIMEOUT-1`, the FSM moves to TIMEOUT.
  - If done and the timeout condition occur in the same cycle, done wins.
- **DONE / TIMEOUT:**
  - `core_reset` is 0 so the core's state remains inspectable.
  - The matching sticky flag is 1 and `cycle_count` holds.
  - `start` restarts at LOAD.
- `start` is ignored while `busy`.
- `ld_valid` outside LOAD is ignored; `ld_ready` is 0 there.

## Timing
- **Reset values:** state IDLE, `core_reset`=1, `core_req`=0, `ld_ready`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `busy`=0, `finished`=0, `timed_out`=0, `cycle_count`=0.
- **Registered outputs:** all outputs are registered except `ld_ready`, which is decoded from state.
- **Latencies:**
  - `start` to LOAD: 1 cycle.
  - Byte accept to `mem_wr_en`: 1 cycle.
  - Last accept to RUN: `RST_CYC`+1 cycles.
  - `core_done` high to `finished`: 1 cycle.
- **Reset mid-operation:** at any state, reset returns to IDLE on the next edge with `core_reset` reasserted. Any in-flight write strobe is dropped.
- **Empty load:** a `start` followed by `ld_last` on the first byte loads exactly 1 byte.

## Configuration
- `RUN_CTRL_TIMEOUT_EN` defined:
  - timeout comparison and the TIMEOUT state are present, as described above.
- `RUN_CTRL_TIMEOUT_EN` undefined:
  - RUN waits indefinitely for `core_done`.
  - `timed_out` is tied 0 and the TIMEOUT state is absent.
  - `cycle_count` saturates at 2^CW−1 instead of wrapping.

## Structure
- **Package `run_ctrl_pkg`:**
  - state enum `run_state_t`
  - default constants for `TIMEOUT`, `RST_CYC` and the 8-bit data-memory address width
- **Sub-module `run_timer`:**
  - the `cycle_count` counter with clear, enable and freeze
  - timeout-match output, plus saturate mode when the macro is undefined
  - the FSM, preload datapath and core handshake stay in `cpu_run_ctrl`

## Test plan
- **Load and run:** reset, `start`, stream 4 bytes 0x11/0x22/0x33/0x44 with `ld_last` on the 4th, `core_done` raised 50 cycles into RUN.
  - Writes land at addresses 0–3 with matching data.
  - `core_reset` is high for 2 cycles.
  - `core_req` is a single-cycle pulse.
  - `finished`=1 and `cycle_count`=50.
- **Full wrap:** stream 256 bytes without `ld_last`.
  - The 256th byte goes to address 255.
  - The FSM enters RST.
  - `ld_ready` is 0 afterwards.
- **Timeout:** `TIMEOUT`=16, `core_done` held 0.
  - `timed_out`=1 after 16 RUN cycles, `cycle_count`=16.
  - `finished`=0.
- **Simultaneous done and timeout:** `core_done` rises on the same cycle `cycle_count`==15 with `TIMEOUT`=16.
  - FSM goes to DONE, `finished`=1, `timed_out`=0.
- **Reset mid-RUN and restart:**
  - Reset mid-RUN gives IDLE and all reset values.
  - `start` while busy is ignored.
  - `start` from DONE clears the flags and reloads from address 0.
